barcode_rdr: RTL and testbench

//  Serial barcode receiver feeding station IDs to the digital core. Decodes the BC line
//  (idle high, one low pulse per bit, pulse width encodes value) into an 8-bit ID.

---
 rtl/barcode_rdr_pkg.sv | 8 +
 rtl/barcode_rdr_sync.sv | 18 +
 rtl/barcode_rdr.sv | 98 +++++++++
 tb/tb_barcode_rdr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/barcode_rdr_pkg.sv
// barcode_rdr_pkg: shared state encoding and default timing constants for the barcode reader
package barcode_rdr_pkg;
  typedef enum logic [2:0] {IDLE, START_LOW, WAIT_FALL, SAMPLE_WAIT, CHECK} state_t;
  localparam int TMR_W_DEF = 22;
  localparam int MIN_START_DEF = 64;
  localparam logic [21:0] TIMEOUT_DEF = 22'h3FFFFF;
  localparam logic [1:0] ID_HDR = 2'b00;
endpackage

// File: rtl/barcode_rdr_sync.sv
// bc_sync: two-flop synchroniser plus history flop, producing edge pulses of the synced line
module bc_sync (
  input  logic clk,
  input  logic RST_n,
  input  logic bc_i,
  output logic bc_s_o,
  output logic fall_o,
  output logic rise_o
);
  logic [2:0] sh_q;
  // Idle line is high, so resetting high avoids a spurious fall after reset.
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) sh_q <= '1;
    else sh_q <= {sh_q[1:0], bc_i};
  assign bc_s_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];
  assign rise_o = ~sh_q[2] & sh_q[1];
endmodule

// File: rtl/barcode_rdr.sv
// barcode_rdr: decodes pulse-width encoded barcode frames into an 8-bit station ID
module barcode_rdr
  import barcode_rdr_pkg::*;
#(
  parameter int TMR_W = TMR_W_DEF,
  parameter int MIN_START = MIN_START_DEF,
  parameter logic [TMR_W-1:0] TIMEOUT = TMR_W'(TIMEOUT_DEF)
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       frame_err
);
  state_t state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, period_q, period_d, timer_inc;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d, id_q, id_d;
  logic id_vld_q, id_vld_d, err_q, err_d;
  logic bc_s, fall, rise;
  bc_sync u_sync (.clk(clk), .RST_n(RST_n), .bc_i(BC), .bc_s_o(bc_s), .fall_o(fall), .rise_o(rise));
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    period_d = period_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    id_d = id_q;
    id_vld_d = id_vld_q & ~clr_ID_vld;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        bit_cnt_d = '0;
        state_d = fall ? START_LOW : IDLE;
      end
      START_LOW:
        if (rise) begin
          state_d = (timer_q < TMR_W'(MIN_START)) ? IDLE : WAIT_FALL;
          period_d = (timer_q < TMR_W'(MIN_START)) ? period_q : timer_q;
          timer_d = '0;
        end
      WAIT_FALL:
        if (fall) begin
          timer_d = '0;
          state_d = SAMPLE_WAIT;
        end
      SAMPLE_WAIT:
        if (timer_q == period_q) begin
          shreg_d = {shreg_q[6:0], bc_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          timer_d = '0;
          state_d = (bit_cnt_q == 3'd7) ? CHECK : WAIT_FALL;
        end
      CHECK: begin
        state_d = IDLE;
        timer_d = '0;
        if (shreg_q[7:6] == ID_HDR) begin
          id_d = shreg_q;
          id_vld_d = 1'b1;
        end else err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides any edge seen in the same cycle.
    if ((state_q inside {START_LOW, WAIT_FALL, SAMPLE_WAIT}) && timer_q == TIMEOUT) begin
      state_d = IDLE;
      timer_d = '0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      period_q <= '0;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      id_q <= '0;
      id_vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      period_q <= period_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      id_q <= id_d;
      id_vld_q <= id_vld_d;
      err_q <= err_d;
    end
  assign ID = id_q;
  assign ID_vld = id_vld_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_barcode_rdr.sv
// tb_barcode_rdr: scoreboard-checked frame decoding, glitch, timeout, clear and reset scenarios
module tb_barcode_rdr;
  import barcode_rdr_pkg::*;
  logic clk = 1'b0, RST_n = 1'b0, BC = 1'b1, clr_ID_vld = 1'b0;
  logic [7:0] ID;
  logic ID_vld, frame_err;
  always #10 clk = ~clk;
  barcode_rdr #(.TMR_W(22), .MIN_START(64), .TIMEOUT(22'd5000)) dut (
    .clk(clk), .RST_n(RST_n), .BC(BC), .clr_ID_vld(clr_ID_vld),
    .ID(ID), .ID_vld(ID_vld), .frame_err(frame_err)
  );
  typedef struct {logic err; logic [7:0] id; logic vld;} exp_t;
  typedef struct {logic [7:0] v; int t;} vec_t;
  exp_t sb[$];
  exp_t e_m;
  int total = 0, bad = 0, cyc = 0, err_cnt = 0, ev_cyc = 0;
  logic [7:0] model_id = 8'h00;
  logic model_vld = 1'b0, vld_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_rng(string nm, int act, int lo, int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask
  // Each error pulse or rising ID_vld retires one scoreboard entry.
  always @(negedge clk) begin
    if (!RST_n) vld_prev = 1'b0;
    else begin
      if (frame_err) err_cnt++;
      if (frame_err || (ID_vld && !vld_prev)) begin
        ev_cyc = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: err=%0b vld=%0b id=%0h with nothing expected", frame_err, ID_vld, ID);
        end else begin
          e_m = sb.pop_front();
          chk("evt_kind", frame_err, e_m.err);
          chk("evt_id", ID, e_m.id);
          chk("evt_vld", ID_vld, e_m.vld);
        end
      end
      vld_prev = ID_vld;
    end
  end
  task automatic clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(logic [7:0] v, int t, int n);
    int lo;
    BC = 1'b0; clks(t / 2);
    BC = 1'b1; clks(t / 2);
    for (int i = 7; i > 7 - n; i--) begin
      lo = v[i] ? t / 4 : 3 * t / 4;
      BC = 1'b0; clks(lo);
      BC = 1'b1; clks(t - lo);
    end
  endtask
  task automatic send_frame(logic [7:0] v, int t);
    exp_t e;
    if (v[7:6] != 2'b00) e = '{1'b1, model_id, model_vld};
    else begin
      model_id = v;
      model_vld = 1'b1;
      e = '{1'b0, v, 1'b1};
    end
    sb.push_back(e);
    send_bits(v, t, 8);
  endtask
  task automatic wait_sb(int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      clks(1);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_timeout: %0d results pending after %0d clks", sb.size(), lim);
      sb.delete();
    end
  endtask
  task automatic clear_vld();
    clr_ID_vld = 1'b1; clks(1);
    clr_ID_vld = 1'b0; clks(1);
    chk("vld_cleared", ID_vld, 0);
    model_vld = 1'b0;
  endtask
  initial begin
    vec_t tbl[7];
    int e0, t0, n, last_fall;
    tbl = '{'{8'h25, 2000}, '{8'h65, 400}, '{8'h00, 400}, '{8'hFF, 400},
            '{8'h3F, 400}, '{8'hC3, 400}, '{8'h80, 400}};
    clks(3);
    chk("rst_id", ID, 8'h00);
    chk("rst_vld", ID_vld, 0);
    chk("rst_err", frame_err, 0);
    RST_n = 1'b1;
    clks(5);
    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt;
      t0 = cyc;
      send_frame(tbl[i].v, tbl[i].t);
      wait_sb(100);
      chk("tbl_err_cnt", err_cnt - e0, tbl[i].v[7:6] != 2'b00);
      chk("tbl_id", ID, model_id);
      if (i == 0) chk_rng("first_latency", ev_cyc - t0, 17000, 17030);
      clear_vld();
      clks(20);
    end
    e0 = err_cnt;
    BC = 1'b0; clks(20);
    BC = 1'b1; clks(50);
    send_frame(8'h0F, 400);
    wait_sb(100);
    chk("glitch_err_cnt", err_cnt - e0, 0);
    chk("glitch_id", ID, 8'h0F);
    chk("glitch_vld", ID_vld, 1);
    clear_vld();
    e0 = err_cnt;
    sb.push_back('{1'b1, model_id, model_vld});
    send_bits(8'hA5, 400, 3);
    last_fall = cyc - 400;
    wait_sb(6000);
    chk_rng("timeout_delay", ev_cyc - last_fall, 5000, 5240);
    chk("timeout_err_cnt", err_cnt - e0, 1);
    clks(10);
    send_frame(8'h11, 400);
    wait_sb(100);
    chk("after_timeout_id", ID, 8'h11);
    clear_vld();
    n = 0;
    fork
      send_frame(8'h2C, 400);
      begin
        while (dut.state_q != CHECK && n < 5000) begin
          @(negedge clk);
          n++;
        end
        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        chk("set_beats_clr", ID_vld, 1);
      end
    join
    wait_sb(100);
    chk("clr_race_id", ID, 8'h2C);
    clear_vld();
    send_frame(8'h15, 400);
    wait_sb(100);
    send_bits(8'h3A, 400, 3);
    BC = 1'b0; clks(50);
    RST_n = 1'b0; clks(2);
    chk("midrst_id", ID, 8'h00);
    chk("midrst_vld", ID_vld, 0);
    chk("midrst_err", frame_err, 0);
    model_id = 8'h00;
    model_vld = 1'b0;
    BC = 1'b1; clks(5);
    RST_n = 1'b1; clks(20);
    send_frame(8'h3A, 400);
    wait_sb(100);
    chk("post_rst_id", ID, 8'h3A);
    chk("post_rst_vld", ID_vld, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
